// File: rtl/hazard_scoreboard_if.sv
// Decode-slot hazard interface: decode fields and pipeline events in, stall/flush/issue and status out.
// No latency of its own; bundles signals between pipeline control and the scoreboard.
// Backpressure is Stall/Flush toward the pipeline; MEM_Busy freezes the scoreboard side.
interface hazard_scoreboard_if;
    logic        ID_Valid;
    logic [2:0]  ID_Rs;
    logic [2:0]  ID_Rd;
    logic        ID_UsesRs;
    logic        ID_UsesRd;
    logic        ID_RegWrite;
    logic        ID_IsLoad;
    logic        Branch_Taken;
    logic        MEM_Busy;
    logic        Stall;
    logic        Flush;
    logic        Issue;
    logic [1:0]  State;
    logic [15:0] Stall_Count;
    logic [15:0] Flush_Count;

    // Pipeline side: presents the decode slot and events, consumes the control decisions.
    modport master (
        output ID_Valid, ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, ID_RegWrite, ID_IsLoad,
        output Branch_Taken, MEM_Busy,
        input  Stall, Flush, Issue, State, Stall_Count, Flush_Count
    );

    // Scoreboard side.
    modport slave (
        input  ID_Valid, ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, ID_RegWrite, ID_IsLoad,
        input  Branch_Taken, MEM_Busy,
        output Stall, Flush, Issue, State, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard with branch flush FSM and saturating stall/flush event counters.
// Stall/Flush/Issue are combinational from registered state; State and counters update one cycle later.
// MEM_Busy freezes every register and forces Stall; a taken branch overrides any hazard stall.
module hazard_scoreboard #(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]  LB_INIT = 2'(LOAD_BUBBLES);
    localparam logic [1:0]  FC_INIT = 2'(FLUSH_CYCLES);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t            state_q, state_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [7:1][1:0]   pend_q, pend_d;
    logic [15:0]       stall_count_q, stall_count_d;
    logic [15:0]       flush_count_q, flush_count_d;

    // r0 is hardwired as never pending, so it can never cause a hazard.
    logic [7:0][1:0]   pend_rd;
    logic              hazard;
    logic              squash;
    logic              stall;
    logic              flush;
    logic              issue;
    logic              stall_ev;

    assign pend_rd  = {pend_q, 2'b00};
    assign hazard   = hz.ID_Valid & ((hz.ID_UsesRs & (pend_rd[hz.ID_Rs] != 2'd0)) |
                                     (hz.ID_UsesRd & (pend_rd[hz.ID_Rd] != 2'd0)));
    assign squash   = hz.Branch_Taken | (state_q == ST_FLUSH);
    assign flush    = squash & ~hz.MEM_Busy;
    assign stall    = hz.MEM_Busy | (hazard & ~squash);
    assign issue    = hz.ID_Valid & ~stall & ~squash;
    assign stall_ev = hazard & ~squash & ~hz.MEM_Busy;

    assign hz.Stall       = stall;
    assign hz.Flush       = flush;
    assign hz.Issue       = issue;
    assign hz.State       = state_q;
    assign hz.Stall_Count = stall_count_q;
    assign hz.Flush_Count = flush_count_q;

    // Scoreboard: an issuing writer sets its destination's bubble count, everything else drains toward zero.
    always_comb begin
        pend_d = pend_q;
        if (!hz.MEM_Busy) begin
            for (int r = 1; r <= 7; r++) begin
                if (issue && hz.ID_RegWrite && (hz.ID_Rd == r[2:0])) begin
                    // A newer ALU write clears an older load's pending bubbles (WAW).
                    pend_d[r] = hz.ID_IsLoad ? LB_INIT : 2'd0;
                end else if (pend_q[r] != 2'd0) begin
                    pend_d[r] = pend_q[r] - 2'd1;
                end
            end
        end
    end

    // Control FSM next state: a taken branch always wins and (re)arms the flush window.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!hz.MEM_Busy) begin
            if (hz.Branch_Taken) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FC_INIT;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hazard) state_d = ST_STALL;
                    end
                    ST_STALL: begin
                        if (!hazard) state_d = ST_RUN;
                    end
                    ST_FLUSH: begin
                        if (flush_cnt_q <= 2'd1) begin
                            state_d     = ST_RUN;
                            flush_cnt_d = 2'd0;
                        end else begin
                            flush_cnt_d = flush_cnt_q - 2'd1;
                        end
                    end
                    default: begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 2'd0;
                    end
                endcase
            end
        end
    end

    // Event counters saturate instead of wrapping; a frozen pipeline records no events.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_ev && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + 16'd1;
        if (flush && (flush_count_q != CNT_MAX))    flush_count_d = flush_count_q + 16'd1;
    end

    // State registers; reset discards all pending hazards and any flush in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 2'd0;
            pend_q        <= '0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pend_q        <= pend_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard using a time-stamp reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Reference tracks, per register, the non-frozen cycle at which it becomes readable.
module tb_hazard_scoreboard;

    localparam int LB = 3;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if hz();

    hazard_scoreboard #(.LOAD_BUBBLES(LB), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mt counts non-frozen cycles; a register is pending while its ready time is in the future.
    int unsigned mt;
    int unsigned mready [8];
    int unsigned mflush_until;
    bit          mlast_stall;
    int          mstall_cnt;
    int          mflush_cnt;

    task automatic m_reset();
        mt = 0;
        foreach (mready[i]) mready[i] = 0;
        mflush_until = 0;
        mlast_stall  = 1'b0;
        mstall_cnt   = 0;
        mflush_cnt   = 0;
    endtask

    function automatic bit m_hazard();
        return hz.ID_Valid && ((hz.ID_UsesRs && (mready[hz.ID_Rs] > mt)) ||
                               (hz.ID_UsesRd && (mready[hz.ID_Rd] > mt)));
    endfunction

    function automatic bit m_squash();
        return hz.Branch_Taken || (mflush_until > mt);
    endfunction

    function automatic bit e_stall();
        return hz.MEM_Busy || (m_hazard() && !m_squash());
    endfunction

    function automatic bit e_flush();
        return m_squash() && !hz.MEM_Busy;
    endfunction

    function automatic bit e_issue();
        return hz.ID_Valid && !e_stall() && !m_squash();
    endfunction

    function automatic logic [1:0] m_state();
        if (mflush_until > mt) return 2'd2;
        if (mlast_stall)       return 2'd1;
        return 2'd0;
    endfunction

    task automatic m_update();
        bit haz, sq, iss;
        if (hz.MEM_Busy) return;
        haz = m_hazard();
        sq  = m_squash();
        iss = e_issue();
        if (iss && hz.ID_RegWrite && (hz.ID_Rd != 3'd0))
            mready[hz.ID_Rd] = hz.ID_IsLoad ? (mt + 1 + LB) : (mt + 1);
        if (hz.Branch_Taken) mflush_until = mt + 1 + FC;
        mlast_stall = haz && !sq;
        if (haz && !sq && (mstall_cnt < 65535)) mstall_cnt++;
        if (sq && (mflush_cnt < 65535)) mflush_cnt++;
        mt++;
    endtask

    // Advance one clock: the model consumes the current inputs, then new inputs may be driven.
    task automatic step();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [2:0] rs, input bit urs, input logic [2:0] rd,
                       input bit urd, input bit we, input bit ld);
        hz.ID_Valid    = 1'b1;
        hz.ID_Rs       = rs;
        hz.ID_UsesRs   = urs;
        hz.ID_Rd       = rd;
        hz.ID_UsesRd   = urd;
        hz.ID_RegWrite = we;
        hz.ID_IsLoad   = ld;
    endtask

    task automatic nop();
        hz.ID_Valid    = 1'b0;
        hz.ID_Rs       = 3'd0;
        hz.ID_UsesRs   = 1'b0;
        hz.ID_Rd       = 3'd0;
        hz.ID_UsesRd   = 1'b0;
        hz.ID_RegWrite = 1'b0;
        hz.ID_IsLoad   = 1'b0;
        hz.Branch_Taken = 1'b0;
        hz.MEM_Busy     = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_stall, exp_flush, exp_issue;
        rst_n = 1'b0;
        m_reset();
        for (int k = 0; k < 8; k++) begin
            ins(3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
            hz.ID_Valid     = k[0];
            hz.Branch_Taken = k[1];
            hz.MEM_Busy     = k[2];
            #2;
            exp_stall = k[2];
            exp_flush = k[1] & ~k[2];
            exp_issue = k[0] & ~k[2] & ~k[1];
            n_checks += 4;
            if (hz.Stall !== exp_stall) begin n_fail++; $display("FAIL reset_stall k=%0d: got %b want %b", k, hz.Stall, exp_stall); end
            if (hz.Flush !== exp_flush) begin n_fail++; $display("FAIL reset_flush k=%0d: got %b want %b", k, hz.Flush, exp_flush); end
            if (hz.Issue !== exp_issue) begin n_fail++; $display("FAIL reset_issue k=%0d: got %b want %b", k, hz.Issue, exp_issue); end
            if ({hz.State, hz.Stall_Count, hz.Flush_Count} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_regs k=%0d: got state=%0d sc=%0d fc=%0d want 0/0/0", k, hz.State, hz.Stall_Count, hz.Flush_Count);
            end
            @(posedge clk);
            #1;
        end
        nop();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_load_use();
        int s0;
        nop();
        ins(3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1);
        #2;
        s0 = mstall_cnt;
        n_checks++;
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL lu_load_issue: got %b want 1", hz.Issue); end
        step();
        ins(3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < LB; k++) begin
            #2;
            n_checks += 3;
            if (hz.Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall c%0d: got %b want 1", k, hz.Stall); end
            if (hz.Issue !== 1'b0) begin n_fail++; $display("FAIL lu_noissue c%0d: got %b want 0", k, hz.Issue); end
            if (hz.State !== ((k == 0) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL lu_state c%0d: got %0d want %0d", k, hz.State, (k == 0) ? 0 : 1); end
            step();
        end
        #2;
        n_checks += 3;
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL lu_issue: got %b want 1", hz.Issue); end
        if (hz.State !== 2'd1) begin n_fail++; $display("FAIL lu_state_stall: got %0d want 1", hz.State); end
        if (hz.Stall_Count !== 16'(s0 + LB)) begin n_fail++; $display("FAIL lu_stall_count: got %0d want %0d", hz.Stall_Count, s0 + LB); end
        step();
        nop();
        #2;
        n_checks++;
        if (hz.State !== 2'd0) begin n_fail++; $display("FAIL lu_state_run: got %0d want 0", hz.State); end
        step();
    endtask

    task automatic test_alu_and_r0();
        ins(3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
        step();
        ins(3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        #2;
        n_checks += 2;
        if (hz.Stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", hz.Stall); end
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL alu_issue: got %b want 1", hz.Issue); end
        step();
        ins(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();
        ins(3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        #2;
        n_checks += 2;
        if (hz.Stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", hz.Stall); end
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL r0_issue: got %b want 1", hz.Issue); end
        step();
        nop();
    endtask

    task automatic test_waw();
        ins(3'd0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1);
        step();
        ins(3'd1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        #2;
        n_checks++;
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL waw_alu_issue: got %b want 1", hz.Issue); end
        step();
        ins(3'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        #2;
        n_checks += 2;
        if (hz.Stall !== 1'b0) begin n_fail++; $display("FAIL waw_reader_stall: got %b want 0", hz.Stall); end
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL waw_reader_issue: got %b want 1", hz.Issue); end
        step();
        nop();
    endtask

    task automatic test_branch_hazard();
        int f0;
        ins(3'd0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1);
        step();
        f0 = mflush_cnt;
        ins(3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        hz.Branch_Taken = 1'b1;
        #2;
        n_checks += 3;
        if (hz.Flush !== 1'b1) begin n_fail++; $display("FAIL bh_flush: got %b want 1", hz.Flush); end
        if (hz.Stall !== 1'b0) begin n_fail++; $display("FAIL bh_stall: got %b want 0", hz.Stall); end
        if (hz.Issue !== 1'b0) begin n_fail++; $display("FAIL bh_issue: got %b want 0", hz.Issue); end
        step();
        hz.Branch_Taken = 1'b0;
        for (int k = 0; k < FC; k++) begin
            #2;
            n_checks += 3;
            if (hz.State !== 2'd2) begin n_fail++; $display("FAIL bh_state c%0d: got %0d want 2", k, hz.State); end
            if (hz.Flush !== 1'b1) begin n_fail++; $display("FAIL bh_flush c%0d: got %b want 1", k, hz.Flush); end
            if (hz.Stall !== 1'b0 || hz.Issue !== 1'b0) begin n_fail++; $display("FAIL bh_squash c%0d: got stall=%b issue=%b want 0/0", k, hz.Stall, hz.Issue); end
            step();
        end
        nop();
        #2;
        n_checks += 2;
        if (hz.State !== 2'd0) begin n_fail++; $display("FAIL bh_state_end: got %0d want 0", hz.State); end
        if (hz.Flush_Count !== 16'(f0 + 1 + FC)) begin n_fail++; $display("FAIL bh_flush_count: got %0d want %0d", hz.Flush_Count, f0 + 1 + FC); end
        step();
    endtask

    task automatic test_mem_busy();
        logic [15:0] sc0, fc0;
        ins(3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1);
        step();
        sc0 = hz.Stall_Count;
        fc0 = hz.Flush_Count;
        ins(3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        hz.MEM_Busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_checks += 3;
            if (hz.Stall !== 1'b1 || hz.Issue !== 1'b0) begin n_fail++; $display("FAIL mb_stall c%0d: got stall=%b issue=%b want 1/0", k, hz.Stall, hz.Issue); end
            if (hz.State !== 2'd0) begin n_fail++; $display("FAIL mb_state c%0d: got %0d want 0", k, hz.State); end
            if (hz.Stall_Count !== sc0 || hz.Flush_Count !== fc0) begin n_fail++; $display("FAIL mb_counts c%0d: got %0d/%0d want %0d/%0d", k, hz.Stall_Count, hz.Flush_Count, sc0, fc0); end
            step();
        end
        hz.MEM_Busy = 1'b0;
        for (int k = 0; k < LB; k++) begin
            #2;
            n_checks++;
            if (hz.Stall !== 1'b1) begin n_fail++; $display("FAIL mb_bubble c%0d: got %b want 1", k, hz.Stall); end
            step();
        end
        #2;
        n_checks += 2;
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL mb_issue: got %b want 1", hz.Issue); end
        if (hz.Stall_Count !== 16'(sc0 + LB)) begin n_fail++; $display("FAIL mb_stall_count: got %0d want %0d", hz.Stall_Count, sc0 + LB); end
        step();
        nop();
    endtask

    task automatic test_reset_mid_stall();
        ins(3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1);
        step();
        ins(3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        #2;
        n_checks++;
        if (hz.State !== 2'd1 || hz.Stall !== 1'b1) begin n_fail++; $display("FAIL rs_pre: got state=%0d stall=%b want 1/1", hz.State, hz.Stall); end
        rst_n = 1'b0;
        #1;
        m_reset();
        n_checks += 3;
        if (hz.State !== 2'd0) begin n_fail++; $display("FAIL rs_state: got %0d want 0", hz.State); end
        if (hz.Stall !== 1'b0 || hz.Issue !== 1'b1) begin n_fail++; $display("FAIL rs_comb: got stall=%b issue=%b want 0/1", hz.Stall, hz.Issue); end
        if (hz.Stall_Count !== 16'd0 || hz.Flush_Count !== 16'd0) begin n_fail++; $display("FAIL rs_counts: got %0d/%0d want 0/0", hz.Stall_Count, hz.Flush_Count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        n_checks += 2;
        if (hz.Stall !== 1'b0) begin n_fail++; $display("FAIL rs_after_stall: got %b want 0", hz.Stall); end
        if (hz.Issue !== 1'b1) begin n_fail++; $display("FAIL rs_after_issue: got %b want 1", hz.Issue); end
        step();
        nop();
    endtask

    task automatic test_saturation();
        bit seen_max;
        seen_max = 1'b0;
        while (!seen_max) begin
            ins(3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1);
            step();
            ins(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < LB; k++) step();
            if (mstall_cnt == 65535) seen_max = 1'b1;
        end
        #2;
        n_checks++;
        if (hz.Stall_Count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %0h want ffff", hz.Stall_Count); end
        for (int g = 0; g < 4; g++) begin
            ins(3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1);
            step();
            ins(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < LB; k++) step();
        end
        #2;
        n_checks += 2;
        if (hz.Stall_Count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h want ffff", hz.Stall_Count); end
        if (hz.Flush_Count !== 16'(mflush_cnt)) begin n_fail++; $display("FAIL sat_flush_count: got %0d want %0d", hz.Flush_Count, mflush_cnt); end
        nop();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            hz.ID_Valid     = ($urandom_range(0, 9) < 8);
            hz.ID_Rs        = 3'($urandom_range(0, 7));
            hz.ID_Rd        = 3'($urandom_range(0, 7));
            hz.ID_UsesRs    = 1'($urandom_range(0, 1));
            hz.ID_UsesRd    = 1'($urandom_range(0, 1));
            hz.ID_RegWrite  = 1'($urandom_range(0, 1));
            hz.ID_IsLoad    = ($urandom_range(0, 9) < 4);
            hz.Branch_Taken = ($urandom_range(0, 9) == 0);
            hz.MEM_Busy     = ($urandom_range(0, 19) < 3);
            #2;
            n_checks += 6;
            if (hz.Stall !== e_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, hz.Stall, e_stall()); end
            if (hz.Flush !== e_flush()) begin n_fail++; $display("FAIL rnd_flush c%0d: got %b want %b", c, hz.Flush, e_flush()); end
            if (hz.Issue !== e_issue()) begin n_fail++; $display("FAIL rnd_issue c%0d: got %b want %b", c, hz.Issue, e_issue()); end
            if (hz.State !== m_state()) begin n_fail++; $display("FAIL rnd_state c%0d: got %0d want %0d", c, hz.State, m_state()); end
            if (hz.Stall_Count !== 16'(mstall_cnt)) begin n_fail++; $display("FAIL rnd_stall_count c%0d: got %0d want %0d", c, hz.Stall_Count, mstall_cnt); end
            if (hz.Flush_Count !== 16'(mflush_cnt)) begin n_fail++; $display("FAIL rnd_flush_count c%0d: got %0d want %0d", c, hz.Flush_Count, mflush_cnt); end
            step();
        end
        nop();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        m_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_alu_and_r0();
        test_waw();
        test_branch_hazard();
        test_mem_busy();
        test_random();
        test_reset_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
